// File: rtl/ws2812b_frame_fetcher.sv
// ws2812b_frame_fetcher
//   Walks LED_COUNT LED positions on every fps tick. For each position it reads
//   3*STRIPE_COUNT bytes from a synchronous-read frame RAM. It applies a
//   brightness shift and channel reordering, packs the bytes into one parallel
//   word and hands the word over with a valid/read handshake. Frame banks are
//   double-buffered; frame ticks that arrive while busy are counted as overruns.
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   frame_start          1-cycle tick that starts a frame (IDLE only)
//   bank_swap            request to toggle the read bank at the next frame start
//   brightness[2:0]      right-shift per colour byte, latched at frame start
//   ram_addr / ram_data  RAM read port, data valid one cycle after address
//   word / word_valid    assembled LED word, held until word_read
//   word_read            consumes word
//   busy, frame_done     frame in progress, 1-cycle end-of-frame pulse
//   bank                 bank currently read
//   overrun_cnt          saturating count of dropped frame_starts
module ws2812b_frame_fetcher #(
   parameter int STRIPE_COUNT = 3,
   parameter int LED_COUNT    = 2,
   parameter int ADDR_WIDTH   = 14,
   parameter int BASE_ADDR    = 0,
   parameter int COLOR_ORDER  = 0
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        frame_start,
   input  logic                        bank_swap,
   input  logic [2:0]                  brightness,
   output logic [ADDR_WIDTH-1:0]       ram_addr,
   input  logic [7:0]                  ram_data,
   output logic [24*STRIPE_COUNT-1:0]  word,
   output logic                        word_valid,
   input  logic                        word_read,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        bank,
   output logic [7:0]                  overrun_cnt
);
   localparam int NB          = 3*STRIPE_COUNT;
   localparam int FRAME_BYTES = NB*LED_COUNT;
   localparam int CW          = $clog2(NB+1);
   localparam int BW          = $clog2(NB-1);
   localparam int LW          = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
   localparam logic [ADDR_WIDTH-1:0] BANK0_ADDR = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] BANK1_ADDR = ADDR_WIDTH'(BASE_ADDR + FRAME_BYTES);

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]          fcnt;
   logic [LW-1:0]          led_idx;
   logic [2:0]             bright_q;
   logic                   swap_pend;
   logic                   new_bank;
   logic [NB-2:0][7:0]     bytes_q;    // all but the last byte of the LED
   logic [NB-1:0][7:0]     bytes_all;
   logic [7:0]             data_scaled;
   logic [24*STRIPE_COUNT-1:0] word_asm;
   logic start, capture, fetch_done, addr_step, consume, last_led;

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = FETCH;
         FETCH:   if (fetch_done)  state_nxt = PRESENT;
         PRESENT: if (word_read)   state_nxt = last_led ? IDLE : FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   // control decode; fcnt counts 0..NB inside FETCH: addresses go out on
   // counts 0..NB-1, data comes back on counts 1..NB
   always_comb begin
      start      = (state == IDLE) && frame_start;
      capture    = (state == FETCH) && (fcnt != '0) && (fcnt != CW'(NB));
      fetch_done = (state == FETCH) && (fcnt == CW'(NB));
      addr_step  = (state == FETCH) && (fcnt < CW'(NB-1));
      consume    = (state == PRESENT) && word_read;
      last_led   = (led_idx == LW'(LED_COUNT-1));
   end

   assign new_bank    = bank ^ (swap_pend | bank_swap);
   assign data_scaled = ram_data >> bright_q;
   // the final byte goes straight from the RAM into the word register
   assign bytes_all   = {data_scaled, bytes_q};

   for (genvar s = 0; s < STRIPE_COUNT; s++) begin : g_stripe
      if (COLOR_ORDER == 0) begin : g_grb
         assign word_asm[24*s +: 24] = {bytes_all[3*s+1], bytes_all[3*s], bytes_all[3*s+2]};
      end else begin : g_raw
         assign word_asm[24*s +: 24] = {bytes_all[3*s], bytes_all[3*s+1], bytes_all[3*s+2]};
      end
   end

   // datapath and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ram_addr    <= '0;
         word        <= '0;
         word_valid  <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         bank        <= 1'b0;
         overrun_cnt <= '0;
         swap_pend   <= 1'b0;
         bright_q    <= '0;
         led_idx     <= '0;
         fcnt        <= '0;
         bytes_q     <= '0;
      end else begin
         frame_done <= 1'b0;
         if (frame_start && busy && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;

         if (start) begin
            swap_pend <= 1'b0;
            bank      <= new_bank;
            bright_q  <= brightness;
            led_idx   <= '0;
            fcnt      <= '0;
            busy      <= 1'b1;
            ram_addr  <= new_bank ? BANK1_ADDR : BANK0_ADDR;
         end else if (bank_swap) begin
            swap_pend <= 1'b1;
         end

         if (state == FETCH) fcnt <= fetch_done ? '0 : fcnt + 1'b1;
         if (addr_step) ram_addr <= ram_addr + 1'b1;
         if (capture) bytes_q[BW'(fcnt - CW'(1))] <= data_scaled;
         if (fetch_done) begin
            word       <= word_asm;
            word_valid <= 1'b1;
         end

         if (consume) begin
            word_valid <= 1'b0;
            if (last_led) begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
            end else begin
               led_idx  <= led_idx + 1'b1;
               // LED bytes are contiguous, so the next LED starts one past the last read
               ram_addr <= ram_addr + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ws2812b_frame_fetcher.sv
module tb_ws2812b_frame_fetcher;
   localparam int AW = 14;
   localparam int WW = 72;
   localparam logic [WW-1:0] W0   = 72'h070608_040305_010002;
   localparam logic [WW-1:0] W1   = 72'h100f11_0d0c0e_0a090b;
   localparam logic [WW-1:0] B1W0 = 72'h19181a_161517_131214;
   localparam logic [WW-1:0] B1W1 = 72'h222123_1f1e20_1c1b1d;
   localparam logic [WW-1:0] C1W0 = 72'h060708_030405_000102;
   localparam logic [WW-1:0] ALL1F = {9{8'h1F}};
   localparam logic [WW-1:0] ALL01 = {9{8'h01}};

   logic clk = 1'b0, resetn = 1'b0, frame_start = 1'b0, bank_swap = 1'b0, word_read = 1'b0;
   logic [2:0] brightness = 3'd0;
   logic [AW-1:0] ram_addr, ram_addr1;
   logic [7:0] ram_data = 8'd0, ram_data1 = 8'd0;
   logic [WW-1:0] word, word1;
   logic word_valid, word_valid1, busy, busy1, frame_done, frame_done1, bank, bank1;
   logic [7:0] overrun_cnt, overrun_cnt1;
   logic [7:0] mem [0:255];

   int n_cmp = 0, n_bad = 0, widx = 0;
   logic [WW-1:0] exp_q[$];
   logic wv_prev = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_data  <= mem[ram_addr[7:0]];
      ram_data1 <= mem[ram_addr1[7:0]];
   end

   ws2812b_frame_fetcher dut (
      .clk(clk), .resetn(resetn), .frame_start(frame_start), .bank_swap(bank_swap),
      .brightness(brightness), .ram_addr(ram_addr), .ram_data(ram_data), .word(word),
      .word_valid(word_valid), .word_read(word_read), .busy(busy), .frame_done(frame_done),
      .bank(bank), .overrun_cnt(overrun_cnt));

   ws2812b_frame_fetcher #(.COLOR_ORDER(1)) dut1 (
      .clk(clk), .resetn(resetn), .frame_start(frame_start), .bank_swap(bank_swap),
      .brightness(brightness), .ram_addr(ram_addr1), .ram_data(ram_data1), .word(word1),
      .word_valid(word_valid1), .word_read(word_read), .busy(busy1), .frame_done(frame_done1),
      .bank(bank1), .overrun_cnt(overrun_cnt1));

   task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every new word presented by the DUT is checked against the scoreboard
   always @(negedge clk) begin
      if (resetn && word_valid && !wv_prev) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %h expected no word", word);
         end else begin
            chk($sformatf("word%0d", widx), word, exp_q.pop_front());
         end
         widx++;
      end
      wv_prev <= resetn & word_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!word_valid && cyc < 60) begin
         tick();
         cyc++;
      end
      if (!word_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_valid: word_valid still 0 after %0d cycles, required 1", cyc);
      end
   endtask

   // read pulse 5 cycles after valid; fs drives frame_start in the same cycle
   task automatic read_word(input logic fs);
      int c;
      wait_valid(c);
      repeat (5) tick();
      word_read   = 1'b1;
      frame_start = fs;
      tick();
      word_read   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int c;
      fill_ramp();
      #12;
      chk("rst_word", word, '0);
      chk("rst_word_valid", word_valid, '0);
      chk("rst_busy", busy, '0);
      chk("rst_frame_done", frame_done, '0);
      chk("rst_bank", bank, '0);
      chk("rst_overrun", overrun_cnt, '0);
      chk("rst_ram_addr", ram_addr, '0);
      tick();
      resetn = 1'b1;
      tick();

      // basic frame, stray read during FETCH, latency, colour order 1
      exp_q.push_back(W0);
      exp_q.push_back(W1);
      start_frame();
      chk("busy_after_start", busy, 1);
      word_read = 1'b1;
      tick();
      word_read = 1'b0;
      wait_valid(c);
      chk("latency", c + 1, 10);
      chk("order1_word0", word1, C1W0);
      read_word(1'b0);
      read_word(1'b0);
      chk("frame_done_pulse", frame_done, 1);
      chk("busy_end", busy, 0);
      chk("valid_after_read", word_valid, 0);
      tick();
      chk("frame_done_clear", frame_done, 0);
      chk("addr_hold", ram_addr, 17);

      // brightness scaling
      for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
      brightness = 3'd3;
      exp_q.push_back(ALL1F);
      exp_q.push_back(ALL1F);
      start_frame();
      read_word(1'b0);
      read_word(1'b0);
      tick();
      brightness = 3'd7;
      exp_q.push_back(ALL01);
      exp_q.push_back(ALL01);
      start_frame();
      brightness = 3'd0;
      read_word(1'b0);
      read_word(1'b0);
      tick();
      fill_ramp();

      // frame_start coinciding with the final read counts as an overrun
      exp_q.push_back(W0);
      exp_q.push_back(W1);
      start_frame();
      read_word(1'b0);
      read_word(1'b1);
      chk("overrun_coincide", overrun_cnt, 1);
      chk("frame_done_coincide", frame_done, 1);
      tick();
      chk("idle_after_coincide", busy, 0);

      // overrun saturation while word is held
      exp_q.push_back(W0);
      start_frame();
      wait_valid(c);
      frame_start = 1'b1;
      repeat (300) tick();
      frame_start = 1'b0;
      chk("overrun_sat", overrun_cnt, 8'd255);
      chk("held_valid", word_valid, 1);
      chk("held_word", word, W0);

      // reset during FETCH of LED 1
      read_word(1'b0);
      tick();
      tick();
      #1 resetn = 1'b0;
      #1;
      chk("arst_valid", word_valid, 0);
      chk("arst_word", word, '0);
      chk("arst_busy", busy, 0);
      chk("arst_overrun", overrun_cnt, 0);
      chk("arst_ram_addr", ram_addr, 0);
      chk("arst_frame_done", frame_done, 0);
      exp_q.delete();
      tick();
      resetn = 1'b1;
      tick();
      exp_q.push_back(W0);
      exp_q.push_back(W1);
      start_frame();
      chk("restart_addr", ram_addr, 0);
      read_word(1'b0);
      read_word(1'b0);
      tick();

      // bank swap mid-frame takes effect at the next frame
      exp_q.push_back(W0);
      exp_q.push_back(W1);
      start_frame();
      tick();
      bank_swap = 1'b1;
      tick();
      bank_swap = 1'b0;
      chk("bank_midframe", bank, 0);
      read_word(1'b0);
      read_word(1'b0);
      exp_q.push_back(B1W0);
      exp_q.push_back(B1W1);
      start_frame();
      chk("bank_next", bank, 1);
      chk("bank1_addr", ram_addr, 18);
      read_word(1'b0);
      read_word(1'b0);

      // two requests stay one toggle
      bank_swap = 1'b1;
      tick();
      tick();
      bank_swap = 1'b0;
      exp_q.push_back(W0);
      exp_q.push_back(W1);
      start_frame();
      chk("bank_repeat", bank, 0);
      read_word(1'b0);
      read_word(1'b0);

      // swap together with frame_start applies to that frame
      exp_q.push_back(B1W0);
      exp_q.push_back(B1W1);
      frame_start = 1'b1;
      bank_swap   = 1'b1;
      tick();
      frame_start = 1'b0;
      bank_swap   = 1'b0;
      chk("bank_coincide", bank, 1);
      read_word(1'b0);
      read_word(1'b0);

      repeat (3) tick();
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
